// File: rtl/spi_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// spi_frame_scheduler_if
//   Bundles the two buses of the SPI frame scheduler:
//     - FWFT sample FIFO read side (head byte, empty flag, fill level, pop)
//     - MCU SPI pins (SCK, active-low SS, MOSI)
//   master : the scheduler (reads the FIFO, drives the SPI pins)
//   slave  : the environment (owns the FIFO, observes the SPI pins)
//
// Handshake: FIFO_DATA is the valid head byte whenever FIFO_EMPTY=0. A
// single-cycle FIFO_RD=1 pops that byte on the same rising edge that the
// scheduler captures it. FIFO_RD is never raised while FIFO_EMPTY=1.
// ---------------------------------------------------------------------------
interface spi_frame_scheduler_if #(
    parameter int LEVEL_W = 10
);
    logic [7:0]         FIFO_DATA;
    logic               FIFO_EMPTY;
    logic [LEVEL_W-1:0] FIFO_LEVEL;
    logic               FIFO_RD;
    logic               MCU_SCK;
    logic               MCU_SS;
    logic               MCU_MOSI;

    modport master (
        input  FIFO_DATA, FIFO_EMPTY, FIFO_LEVEL,
        output FIFO_RD, MCU_SCK, MCU_SS, MCU_MOSI
    );

    modport slave (
        output FIFO_DATA, FIFO_EMPTY, FIFO_LEVEL,
        input  FIFO_RD, MCU_SCK, MCU_SS, MCU_MOSI
    );
endinterface

// File: rtl/spi_frame_scheduler.sv
// ---------------------------------------------------------------------------
// spi_frame_scheduler
//   Moves packed GPS I/Q bytes from the FWFT sample FIFO to the MCU over an
//   SPI mode-0 link. Each frame is: SYNC_BYTE, sequence byte, FRAME_BYTES
//   payload bytes, all MSB first, framed by chip-select setup/hold and an
//   inter-frame gap.
//
// Ports:
//   MCU_CLK_25_000 : system clock, rising edge
//   MCU_RST_N      : asynchronous active-low reset
//   ENABLE         : permits new frames to start
//   bus            : FIFO read side + SPI pins (spi_frame_scheduler_if.master)
//   BUSY           : high whenever the FSM is not IDLE
//   UNDERRUN       : sticky, set when a payload byte was due but the FIFO
//                    was empty (a zero byte is sent instead)
//   SEQ            : sequence number carried by the next frame
//   FSM_STATE      : current FSM state encoding (debug/observation)
// ---------------------------------------------------------------------------
module spi_frame_scheduler #(
    parameter int         FRAME_BYTES = 64,
    parameter int         SCK_DIV     = 2,
    parameter int         CS_SETUP    = 2,
    parameter int         GAP_CLKS    = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         LEVEL_W     = 10
) (
    input  logic                  MCU_CLK_25_000,
    input  logic                  MCU_RST_N,
    input  logic                  ENABLE,
    spi_frame_scheduler_if.master bus,
    output logic                  BUSY,
    output logic                  UNDERRUN,
    output logic [7:0]            SEQ,
    output logic [2:0]            FSM_STATE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [15:0] CS_LAST   = 16'(CS_SETUP - 1);
    localparam logic [15:0] HALF_LAST = 16'(SCK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CLKS - 1);
    // Byte index 0 is the sync byte, 1 the sequence byte, 2.. the payload.
    localparam logic [8:0]  LAST_BYTE = 9'(FRAME_BYTES + 1);

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;      // clocks within LEAD/TRAIL/GAP or SCK half-period
    logic         sck_q, sck_d;      // 0: low half of the bit, 1: high half
    logic [2:0]   bit_q, bit_d;      // bit being sent, 7 down to 0
    logic [8:0]   byte_q, byte_d;    // byte being sent within the frame
    logic [7:0]   sh_q, sh_d;        // shift register, MOSI = sh_q[7]
    logic [7:0]   seq_q, seq_d;
    logic         und_q, und_d;
    logic         fifo_rd;
    logic         in_frame;
    logic         start_ok;
    logic [LEVEL_W-1:0] level;

    assign level    = bus.FIFO_LEVEL;
    assign start_ok = ENABLE && (int'(level) >= FRAME_BYTES);

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        seq_d   = seq_q;
        und_d   = und_q;
        fifo_rd = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (start_ok) begin
                    state_d = LEAD;
                    sh_d    = SYNC_BYTE;
                end
            end

            LEAD: begin
                if (cnt_q == CS_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = 16'd0;
                    sck_d   = 1'b0;
                    bit_d   = 3'd7;
                    byte_d  = 9'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            SHIFT: begin
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = 16'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // End of a bit: advance MOSI for the next bit, which
                        // starts with SCK low.
                        sck_d = 1'b0;
                        if (bit_q != 3'd0) begin
                            bit_d = bit_q - 3'd1;
                            sh_d  = {sh_q[6:0], 1'b0};
                        end else if (byte_q == LAST_BYTE) begin
                            // Shift register is left alone so MOSI holds
                            // the last bit through TRAIL.
                            state_d = TRAIL;
                        end else begin
                            bit_d  = 3'd7;
                            byte_d = byte_q + 9'd1;
                            if (byte_q == 9'd0) begin
                                sh_d = seq_q;
                            end else if (bus.FIFO_EMPTY) begin
                                sh_d  = 8'h00;
                                und_d = 1'b1;
                            end else begin
                                // FWFT: head byte is captured and popped
                                // on the same edge.
                                sh_d    = bus.FIFO_DATA;
                                fifo_rd = 1'b1;
                            end
                        end
                    end
                end
            end

            TRAIL: begin
                if (cnt_q == CS_LAST) begin
                    state_d = GAP;
                    cnt_d   = 16'd0;
                    seq_d   = seq_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge MCU_CLK_25_000 or negedge MCU_RST_N) begin
        if (!MCU_RST_N) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            sck_q   <= 1'b0;
            bit_q   <= 3'd7;
            byte_q  <= 9'd0;
            sh_q    <= 8'h00;
            seq_q   <= 8'h00;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            seq_q   <= seq_d;
            und_q   <= und_d;
        end
    end

    // Pin outputs decode from the state register, so an asynchronous reset
    // returns every pin to idle immediately.
    assign in_frame     = (state_q == LEAD) || (state_q == SHIFT) || (state_q == TRAIL);
    assign bus.MCU_SS   = !in_frame;
    assign bus.MCU_SCK  = (state_q == SHIFT) && sck_q;
    assign bus.MCU_MOSI = in_frame && sh_q[7];
    assign bus.FIFO_RD  = fifo_rd;

    assign BUSY      = (state_q != IDLE);
    assign UNDERRUN  = und_q;
    assign SEQ       = seq_q;
    assign FSM_STATE = state_q;

endmodule

// File: doc/spi_frame_scheduler.md
Name: spi_frame_scheduler

Overview:
- Sequences the MCU-side SPI link that carries packed GPS I/Q sample bytes to the microcontroller, in the MCU_CLK_25_000 domain.
- Pulls bytes from the first-word-fall-through sample FIFO filled by the GPS-side packer.
- Wraps each payload in a framed SPI transaction: sync byte, sequence byte, then FRAME_BYTES payload bytes.
- Drives MCU_SCK, MCU_SS and MCU_MOSI directly in SPI mode 0, with controlled chip-select setup, hold and inter-frame gap.

Parameters:
- FRAME_BYTES, 64, payload bytes per frame (1..255)
- SCK_DIV, 2, SCK half-period in clocks (>=1); SCK period = 2*SCK_DIV clocks
- CS_SETUP, 2, clocks of SS low before the first SCK edge, and SS low after the last SCK fall
- GAP_CLKS, 8, minimum clocks of SS high between frames (>=1)
- SYNC_BYTE, 8'hA5, first byte of every frame
- LEVEL_W, 10, width of FIFO_LEVEL

Ports:
- MCU_CLK_25_000  in  1  system clock, rising edge
- MCU_RST_N  in  1  asynchronous active-low reset
- ENABLE  in  1  permits new frames to start
- FIFO_DATA  in  8  FWFT head byte; valid while FIFO_EMPTY=0
- FIFO_EMPTY  in  1  FIFO empty flag
- FIFO_LEVEL  in  LEVEL_W  bytes currently in the FIFO
- FIFO_RD  out  1  one-cycle pop strobe
- MCU_SCK  out  1  SPI clock; idles low
- MCU_SS  out  1  chip select, active low
- MCU_MOSI  out  1  serial data, MSB first
- BUSY  out  1  high in any state other than IDLE
- UNDERRUN  out  1  sticky underrun flag; cleared only by reset
- SEQ  out  8  sequence number of the next frame

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-frame): FIFO_RD=0, MCU_SCK=0, MCU_SS=1, MCU_MOSI=0, BUSY=0, UNDERRUN=0, SEQ=0, FSM=IDLE. A frame interrupted by reset is abandoned; no resume.
- States: IDLE, LEAD, SHIFT, TRAIL, GAP.
- IDLE -> LEAD when ENABLE=1 and FIFO_LEVEL>=FRAME_BYTES, sampled in the same clock. MCU_SS falls on entry to LEAD.
- LEAD:
  - Lasts CS_SETUP clocks.
  - The shift register is loaded with SYNC_BYTE on entry, so MOSI carries its MSB.
  - -> SHIFT.
- SHIFT:
  - Each bit is SCK_DIV clocks with SCK low, then SCK_DIV clocks with SCK high.
  - MOSI changes only at the start of a bit, while SCK is low; the MCU samples on the SCK rise.
  - A byte takes 16*SCK_DIV clocks.
  - Byte order: SYNC_BYTE, SEQ, then payload 0..FRAME_BYTES-1.
- Payload loading:
  - At the clock that ends bit 0 of the preceding byte, the next payload byte loads from FIFO_DATA.
  - FIFO_RD pulses for exactly that one clock.
  - No FIFO_RD for the sync or SEQ bytes; exactly FRAME_BYTES pops per frame.
- Underrun: if FIFO_EMPTY=1 when a payload byte is due, 8'h00 is sent, FIFO_RD stays 0, UNDERRUN sets, and the frame continues to full length.
- SHIFT -> TRAIL after the last bit's high phase. SCK returns low and MOSI holds its last value.
- TRAIL:
  - Lasts CS_SETUP clocks, then MCU_SS rises.
  - SEQ increments mod 256 (255 -> 0) on that same edge.
  - -> GAP.
- GAP: lasts GAP_CLKS clocks with SS high, SCK low, MOSI=0; -> IDLE.
- Frame start is re-evaluated in IDLE, so back-to-back frames have exactly GAP_CLKS+1 clocks of SS high.
- ENABLE deasserted mid-frame: the current frame completes normally; no new frame starts.
- FIFO_LEVEL changes during a frame are ignored; only the start check and per-byte FIFO_EMPTY matter.
- Frame length, SS low time: CS_SETUP*2 + (FRAME_BYTES+2)*16*SCK_DIV clocks.

Test Plan:
- Parameters FRAME_BYTES=4, SCK_DIV=2, CS_SETUP=2, GAP_CLKS=8. FIFO holds 01 02 03 04, ENABLE=1 -> MOSI stream A5 00 01 02 03 04 MSB first, sampled on SCK rise. SS low for 196 clocks, 48 SCK rising edges, 4 FIFO_RD single-cycle pulses, SEQ becomes 1 when SS rises.
- FIFO_LEVEL=3 with ENABLE=1 -> SS stays high and BUSY=0. Raise the level to 4 -> LEAD begins the next clock.
- FIFO continuously refilled, 300 frames -> SEQ byte goes ...FE FF 00 01.... Exactly 9 clocks of SS high between frames.
- FIFO_EMPTY forced to 1 before payload byte 3 -> that byte is sent as 00 with no FIFO_RD pulse. UNDERRUN=1 and stays 1 through later frames. Frame length is still 196 clocks.
- ENABLE dropped during the sequence byte -> the frame completes to 196 clocks, then IDLE with no new frame.
- MCU_RST_N pulsed low mid-payload, away from a clock edge -> SS=1, SCK=0, MOSI=0, FIFO_RD=0, SEQ=0 immediately. After release, the next frame starts with sync A5 and SEQ 00.
